matrix_mul_sequencer: RTL
=========================

// Module: matrix_mul_sequencer
// PURPOSE
//  Initiator side of the matrix multiplier start/done interface. Collects two 4x4 fixed-point
//  operands from an element-serial valid/ready stream. Packs them into the 256-bit matA/matB buses
//  and pulses start. Waits for done, captures res_mat and streams the 16 result elements back out.
//  Sits between the transform-setup logic (camera/model matrices) and the matrix multiplier core.
// PARAMETERS
//  ELEM_W   16    fixed-point element width (bits); matrix bus width = 16*ELEM_W
//  TIMEOUT  1024  max cycles in WAIT before error abort; 0 disables timeout
// PORTS
//  Clk        in   1         system clock, all logic rising-edge
//  Reset      in   1         synchronous reset, ACTIVE-LOW (Reset==0 resets on Clk edge)
//  in_valid   in   1         input element valid
//  in_ready   out  1         sequencer accepts input element
//  in_data    in   ELEM_W    operand element, row-major, A then B
//  in_keep_b  in   1         sampled with first A element: 1 = reuse stored B, skip B load
//  mm_matA    out  16*ELEM_W packed operand A to multiplier
//  mm_matB    out  16*ELEM_W packed operand B to multiplier
//  mm_start   out  1         one-cycle start pulse to multiplier
//  mm_done    in   1         multiplier result valid (pulse or level)
//  mm_res     in   16*ELEM_W packed result from multiplier
//  out_valid  out  1         result element valid
//  out_ready  in   1         downstream accepts result element
//  out_data   out  ELEM_W    result element, row-major
//  out_last   out  1         high with element 15 of result
//  busy       out  1         state != IDLE
//  err        out  1         sticky timeout flag; cleared by reset or next accepted A element
// BEHAVIOUR
//  Packing: element (r,c), idx=4r+c, occupies bits [ELEM_W*idx +: ELEM_W] of each 256-bit bus.
//  Reset (Reset==0 at edge): state=IDLE, idx=0, in_ready=0, mm_start=0, out_valid=0,
//   out_last=0, busy=0, err=0; mm_matA/mm_matB/result regs cleared to 0. Mid-operation reset aborts.
//  FSM: IDLE -> LOAD_A -> [LOAD_B] -> START -> WAIT -> STREAM -> IDLE.
//   IDLE:   in_ready=1; in_valid&in_ready writes A[0], latches keep_b, clears err, idx=1, -> LOAD_A.
//   LOAD_A: in_ready=1; each handshake writes A[idx], idx++; after A[15] -> LOAD_B (keep_b=0)
//           or START (keep_b=1, mm_matB keeps previous contents).
//   LOAD_B: in_ready=1; writes B[0..15]; after B[15] -> START.
//   START:  mm_start=1 for exactly one cycle; in_ready=0; -> WAIT.
//   WAIT:   mm_done sampled from cycle after START; on mm_done capture mm_res -> STREAM, idx=0.
//           mm_done in START cycle is ignored. Timeout counter hits TIMEOUT -> err=1, -> IDLE.
//   STREAM: out_valid=1, out_data=res[idx]; idx++ on out_valid&out_ready; out_last=(idx==15);
//           handshake on idx 15 -> IDLE. out_data stable while out_valid&!out_ready.
//  in_ready is 0 in START/WAIT/STREAM (no overlap of load and stream).
//  mm_matA/mm_matB only change on input handshakes. They are stable from START through WAIT.
//  Operand latency: the last B handshake at cycle t gives mm_start at t+1.
//  Result latency: mm_done at cycle d gives the first out_valid at d+1.
//  Element values pass through unmodified; no arithmetic, saturation or sign handling here.
//  idx is a 4-bit counter; wraps 15->0 only on state exit. The timeout counter is $clog2(TIMEOUT+1)
//  bits and is cleared on WAIT entry.
// STRUCTURE
//  Shared package mm_pkg: ELEM_W default, MAT_ELEMS=16, seq_state_t enum
//   {IDLE,LOAD_A,LOAD_B,START,WAIT,STREAM}, function elem_lsb(idx)=ELEM_W*idx.
//  One natural sub-module: mat_elem_reg (16-entry write-by-index register bank with packed 256-bit
//   read). Used twice, for A and B. Result capture is a plain 256-bit register with an indexed mux.
// TESTING
//  1 Load A=identity (0x0100 on diagonal, Q8.8), B=0..15; stub multiplier returns B after 3 cycles
//    -> mm_start one pulse 1 cycle after B[15]; out_data 0..15 in order; out_last on 15th.
//  2 Same stimulus, then a second op with in_keep_b=1 and 16 A elements only
//    -> mm_start after A[15]; mm_matB unchanged.
//  3 out_ready toggled 1/0 randomly during STREAM
//    -> no element dropped or repeated; out_data held while stalled.
//  4 Stub never asserts mm_done, TIMEOUT=8 -> err=1 and state IDLE 8 cycles into WAIT;
//    next A element clears err.
//  5 Reset driven low while in LOAD_B (idx=7) and while in STREAM (idx=4)
//    -> all outputs at reset values the next cycle; a fresh load then completes normally.
//  6 mm_done high during START cycle only -> ignored; a later done is captured; no early stream.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix multiplier sequencer.
package mm_pkg;

  localparam int DEF_ELEM_W = 16;
  localparam int MAT_ELEMS  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    STREAM
  } seq_state_t;

  // Bit offset of element idx (row-major, idx = 4*row + col) inside a packed matrix bus.
  function automatic int unsigned elem_lsb(input logic [3:0] idx,
                                           input int unsigned elem_w = DEF_ELEM_W);
    return elem_w * idx;
  endfunction

endpackage

// File: rtl/matrix_mul_sequencer_if.sv
// Operand stream, multiplier start/done and result stream signals of the sequencer.
// master = sequencer side, slave = surrounding logic (setup stream, multiplier, consumer).
interface matrix_mul_sequencer_if #(
  parameter int ELEM_W = mm_pkg::DEF_ELEM_W
);
  localparam int MAT_W = mm_pkg::MAT_ELEMS * ELEM_W;

  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;
  logic              in_keep_b;
  logic [MAT_W-1:0]  mm_matA;
  logic [MAT_W-1:0]  mm_matB;
  logic              mm_start;
  logic              mm_done;
  logic [MAT_W-1:0]  mm_res;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              err;

  modport master (
    input  in_valid, in_data, in_keep_b, mm_done, mm_res, out_ready,
    output in_ready, mm_matA, mm_matB, mm_start, out_valid, out_data, out_last, busy, err
  );

  modport slave (
    output in_valid, in_data, in_keep_b, mm_done, mm_res, out_ready,
    input  in_ready, mm_matA, mm_matB, mm_start, out_valid, out_data, out_last, busy, err
  );

endinterface

// File: rtl/mat_elem_reg.sv
// 16-entry element register bank, written one element at a time by index and
// read back as a single packed row-major matrix bus.
module mat_elem_reg
  import mm_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [3:0]                  widx,
  input  logic [ELEM_W-1:0]           wdata,
  output logic [MAT_ELEMS*ELEM_W-1:0] mat
);

  localparam int MAT_W = MAT_ELEMS * ELEM_W;
  localparam int LSB_W = $clog2(MAT_W);

  logic [MAT_W-1:0] mat_q, mat_d;
  logic [LSB_W-1:0] wr_lsb;

  assign wr_lsb = LSB_W'(elem_lsb(widx, ELEM_W));

  // Overwrite only the addressed element; every other element holds its value.
  always_comb begin
    mat_d = mat_q;
    if (we) begin
      mat_d[wr_lsb +: ELEM_W] = wdata;
    end
  end

  // Bank storage, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) mat_q <= '0;
    else        mat_q <= mat_d;
  end

  assign mat = mat_q;

endmodule

// File: rtl/matrix_mul_sequencer.sv
// Initiator for the matrix multiplier: loads A (and optionally B) element by element,
// fires a one-cycle start, waits for done (with optional timeout) and streams the
// 16 result elements back out in row-major order.
module matrix_mul_sequencer
  import mm_pkg::*;
#(
  parameter int ELEM_W  = DEF_ELEM_W,
  parameter int TIMEOUT = 1024
) (
  input logic                    Clk,
  input logic                    Reset,
  matrix_mul_sequencer_if.master bus
);

  localparam int MAT_W = MAT_ELEMS * ELEM_W;
  localparam int LSB_W = $clog2(MAT_W);
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  seq_state_t       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             keep_b_q, keep_b_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [MAT_W-1:0] res_q, res_d;

  logic             a_we, b_we;
  logic             in_ready;
  logic             in_hs;
  logic             out_hs;
  logic [LSB_W-1:0] rd_lsb;

  assign in_ready = Reset && ((state_q == IDLE) || (state_q == LOAD_A) || (state_q == LOAD_B));
  assign in_hs    = bus.in_valid && in_ready;
  assign out_hs   = (state_q == STREAM) && bus.out_ready;

  mat_elem_reg #(.ELEM_W(ELEM_W)) u_mat_a (
    .clk   (Clk),
    .rst_n (Reset),
    .we    (a_we),
    .widx  (idx_q),
    .wdata (bus.in_data),
    .mat   (bus.mm_matA)
  );

  mat_elem_reg #(.ELEM_W(ELEM_W)) u_mat_b (
    .clk   (Clk),
    .rst_n (Reset),
    .we    (b_we),
    .widx  (idx_q),
    .wdata (bus.in_data),
    .mat   (bus.mm_matB)
  );

  // Next-state, element index, timeout and result capture; idx wraps 15->0 on each state exit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    keep_b_d = keep_b_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    res_d    = res_q;
    a_we     = 1'b0;
    b_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          a_we     = 1'b1;
          keep_b_d = bus.in_keep_b;
          err_d    = 1'b0;
          idx_d    = 4'd1;
          state_d  = LOAD_A;
        end
      end
      LOAD_A: begin
        if (in_hs) begin
          a_we  = 1'b1;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = keep_b_q ? START : LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (in_hs) begin
          b_we  = 1'b1;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = START;
          end
        end
      end
      START: begin
        // A done seen here belongs to a previous operation and is deliberately ignored.
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mm_done) begin
          res_d   = bus.mm_res;
          idx_d   = 4'd0;
          state_d = STREAM;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      STREAM: begin
        if (out_hs) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      keep_b_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      keep_b_q <= keep_b_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      res_q    <= res_d;
    end
  end

  assign rd_lsb       = LSB_W'(elem_lsb(idx_q, ELEM_W));
  assign bus.in_ready  = in_ready;
  assign bus.mm_start  = (state_q == START);
  assign bus.out_valid = (state_q == STREAM);
  assign bus.out_data  = res_q[rd_lsb +: ELEM_W];
  assign bus.out_last  = (state_q == STREAM) && (idx_q == 4'd15);
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;

endmodule
